stream_arb_mux: RTL and testbench

- Parametrised, registered N:1 stream multiplexer; successor to the combinational 16:1 32-bit data mux.
- Inputs are NUM_IN valid/ready channels. The block picks one channel by fixed-priority or round-robin arbitration and forwards the chosen beat through one output register stage.
- Packet lock: once a multi-beat packet starts on a channel, that channel keeps the grant until its last beat.
- Used to merge request streams (e.g. memory/IO requesters) onto one shared datapath.

---
 rtl/stream_arb_mux.sv | 183 ++++++++++++++++++
 tb/tb_stream_arb_mux.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux.sv
// Registered N:1 valid/ready stream mux with fixed-priority or round-robin
// arbitration and packet lock: a started multi-beat packet owns the output until its last beat.

module stream_arb_mux_lane #(
  parameter int WIDTH = 32
) (
  input  logic             gnt_i,
  input  logic             rdy_en_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             xfer_o,
  output logic             last_o,
  output logic [WIDTH-1:0] data_o
);

  // Non-granted lanes contribute zeros so the top can OR-reduce across lanes.
  assign ready_o = gnt_i & rdy_en_i;
  assign xfer_o  = ready_o & valid_i;
  assign last_o  = gnt_i & valid_i & last_i;
  assign data_o  = gnt_i ? data_i : '0;

endmodule

module stream_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rr_mode,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready,
  output logic                    locked
);

  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [SEL_W-1:0] sel;
  } beat_t;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             mode_q, mode_d;
  beat_t            out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic                          load, any_valid, rdy_en;
  logic [NUM_IN-1:0]             above_ptr, masked, gnt_oh;
  logic [SEL_W-1:0]              g_idx, g_nxt;
  logic [NUM_IN-1:0]             lane_xfer, lane_last;
  logic [NUM_IN-1:0][WIDTH-1:0]  lane_data;
  logic                          xfer_any, last_g;
  logic [WIDTH-1:0]              data_g;

  function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_IN-1:0] vec);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_IN - 1; i >= 0; i--)
      if (vec[i]) r = SEL_W'(i);
    return r;
  endfunction

  assign load      = ~out_valid_q | out_ready;
  assign any_valid = |in_valid;
  // Reset gating keeps every ready low while reset_n is held, even with valids present.
  assign rdy_en    = reset_n & load & ((state_q == LOCKED) | any_valid);

  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < NUM_IN; i++)
      above_ptr[i] = (SEL_W'(i) >= ptr_q);
    masked = in_valid & above_ptr;

    // Round-robin: first valid at/after the pointer, else wrap to the lowest valid.
    if (state_q == LOCKED)          g_idx = lock_idx_q;
    else if (rr_mode && |masked)    g_idx = lowest_idx(masked);
    else                            g_idx = lowest_idx(in_valid);

    gnt_oh = '0;
    for (int i = 0; i < NUM_IN; i++)
      gnt_oh[i] = (SEL_W'(i) == g_idx) & ((state_q == LOCKED) | any_valid);
  end

  assign g_nxt = (g_idx == SEL_W'(NUM_IN - 1)) ? '0 : g_idx + SEL_W'(1);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    stream_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt_i    (gnt_oh[i]),
      .rdy_en_i (rdy_en),
      .valid_i  (in_valid[i]),
      .last_i   (in_last[i]),
      .data_i   (in_data[i*WIDTH +: WIDTH]),
      .ready_o  (in_ready[i]),
      .xfer_o   (lane_xfer[i]),
      .last_o   (lane_last[i]),
      .data_o   (lane_data[i])
    );
  end

  always_comb begin
    data_g = '0;
    for (int i = 0; i < NUM_IN; i++)
      data_g = data_g | lane_data[i];
  end

  assign xfer_any = |lane_xfer;
  assign last_g   = |lane_last;

  always_comb begin
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (load) begin
      out_valid_d = xfer_any;
      if (xfer_any) out_d = '{data: data_g, last: last_g, sel: g_idx};
    end

    // The mode seen at packet start decides whether its completion moves the pointer.
    if (xfer_any) begin
      unique case (state_q)
        IDLE: begin
          if (!last_g) begin
            state_d    = LOCKED;
            lock_idx_d = g_idx;
            mode_d     = rr_mode;
          end else if (rr_mode) begin
            ptr_d = g_nxt;
          end
        end
        LOCKED: begin
          if (last_g) begin
            state_d = IDLE;
            if (mode_q) ptr_d = g_nxt;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lock_idx_q  <= '0;
      ptr_q       <= '0;
      mode_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      ptr_q       <= ptr_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_q.data;
  assign out_last  = out_q.last;
  assign out_sel   = out_q.sel;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_arb_mux.sv
// Randomized + directed bench for stream_arb_mux: a transaction-level arbiter model
// pushes expected beats into a queue, a separate monitor pops them on output handshakes.

module tb_stream_arb_mux;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 16;
  localparam int SEL_W  = 4;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    rr_mode;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid, in_last, in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid, out_last, out_ready, locked;
  logic [SEL_W-1:0]        out_sel;

  stream_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clock(clock), .reset_n(reset_n), .rr_mode(rr_mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready), .locked(locked)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules evaluated once per cycle on the values the
  // DUT will sample at the next rising edge.
  bit m_locked, m_mode, m_ov;
  int m_lock, m_ptr;

  always @(negedge clock) begin
    bit               load, xfer, lst;
    int               g;
    logic [NUM_IN-1:0] er;
    if (!reset_n) begin
      m_locked = 0; m_mode = 0; m_ov = 0; m_lock = 0; m_ptr = 0;
      exp_q.delete();
      chk("in_ready_in_reset", in_ready, 0);
    end else begin
      load = !m_ov || out_ready;
      g = -1;
      if (m_locked) g = m_lock;
      else if (rr_mode) begin
        for (int k = 0; k < NUM_IN; k++)
          if (g < 0 && in_valid[(m_ptr + k) % NUM_IN]) g = (m_ptr + k) % NUM_IN;
      end else begin
        for (int k = 0; k < NUM_IN; k++)
          if (g < 0 && in_valid[k]) g = k;
      end
      er = '0;
      if (load && g >= 0) er[g] = 1'b1;
      chk("in_ready", in_ready, er);
      if (load) begin
        xfer = (g >= 0) && in_valid[g];
        m_ov = xfer;
        if (xfer) begin
          lst = in_last[g];
          exp_q.push_back('{data: in_data[g*WIDTH +: WIDTH], last: lst, sel: g});
          if (!m_locked) begin
            if (!lst) begin m_locked = 1; m_lock = g; m_mode = rr_mode; end
            else if (rr_mode) m_ptr = (g + 1) % NUM_IN;
          end else if (lst) begin
            m_locked = 0;
            if (m_mode) m_ptr = (g + 1) % NUM_IN;
          end
        end
      end
    end
  end

  // Monitor: one comparison set per accepted output beat, plus hold-stability under backpressure.
  bit               hold_prev = 0;
  logic [WIDTH-1:0] prev_data;
  logic [SEL_W-1:0] prev_sel;
  logic             prev_last;

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n || !out_valid) hold_prev = 0;
    else begin
      if (hold_prev) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_sel", out_sel, prev_sel);
        chk("hold_last", out_last, prev_last);
      end
      if (out_ready) begin
        hold_prev = 0;
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sel", out_sel, e.sel);
          chk("out_last", out_last, e.last);
          chk("locked", locked, !e.last);
        end
      end else begin
        hold_prev = 1;
        prev_data = out_data; prev_sel = out_sel; prev_last = out_last;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [NUM_IN-1:0] v, input logic [NUM_IN-1:0] l,
                       input logic rr, input logic ordy);
    in_valid  = v;
    in_last   = l;
    rr_mode   = rr;
    out_ready = ordy;
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
    cyc();
  endtask

  initial begin
    reset_n = 1'b0;
    rr_mode = 1'b0;
    out_ready = 1'b1;
    in_valid = '1;
    in_last = '1;
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
    repeat (2) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_locked", locked, 0);
    chk("rst_out_data", out_data, 0);
    reset_n = 1'b1;

    drive(16'hFFFF, 16'hFFFF, 0, 1);
    // Fixed priority: 3 wins over 5 until it drops.
    repeat (3) drive(16'h0028, 16'hFFFF, 0, 1);
    drive(16'h0020, 16'hFFFF, 0, 1);
    // Round-robin across the wrap point.
    repeat (4) drive(16'h8001, 16'hFFFF, 1, 1);
    // Packet lock on channel 2 with a bubble while channel 1 waits.
    drive(16'h0004, 16'hFFFB, 0, 1);
    drive(16'h0006, 16'hFFFB, 0, 1);
    drive(16'h0002, 16'hFFFB, 0, 1);
    drive(16'h0006, 16'hFFFF, 0, 1);
    drive(16'h0002, 16'hFFFF, 0, 1);
    // Backpressure.
    drive(16'h0010, 16'hFFFF, 0, 1);
    repeat (4) drive(16'h0010, 16'hFFFF, 0, 0);
    repeat (2) drive(16'h0010, 16'hFFFF, 0, 1);
    drive(16'h0000, 16'hFFFF, 0, 1);
    // Mid-packet reset while locked to channel 7; pointer sits at 6 beforehand.
    drive(16'h0020, 16'hFFFF, 1, 1);
    drive(16'h0080, 16'hFF7F, 1, 1);
    drive(16'h0080, 16'hFF7F, 1, 1);
    chk("pre_rst_locked", locked, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_out_valid", out_valid, 0);
    in_valid = '0;
    repeat (2) cyc();
    reset_n = 1'b1;
    // From pointer 0 channel 3 wins; a stale pointer 6 would pick 9.
    repeat (3) drive(16'h0208, 16'hFFFF, 1, 1);
    drive(16'h0000, 16'hFFFF, 1, 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++)
      drive(NUM_IN'($urandom & $urandom), NUM_IN'($urandom), 1'($urandom),
            ($urandom_range(0, 9) < 7));

    repeat (6) drive(16'h0000, 16'hFFFF, 0, 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
